// File: rtl/rslt_writer.sv
// rslt_writer: conv output write-back with optional ReLU and
// 2x2/stride-2 max-pool, driving the result BRAM write port.
//
// Ports:
//   clk, reset (async, active-low)
//   start       level; rising edge arms a frame, low aborts/releases
//   pool_en     2x2 max-pool enable (sampled on start rise)
//   relu_en     clamp negatives to zero (sampled on start rise)
//   result_cols last column index (sampled on start rise)
//   result_rows last row index (sampled on start rise)
//   base_addr   first write address (sampled on start rise)
//   pix_valid   pix_data valid, no backpressure
//   pix_data    signed conv result, row-major
//   rslt_we     BRAM write enable, one cycle per word
//   rslt_addr   BRAM write address
//   rslt_wdata  BRAM write data
//   busy        high while running a frame
//   done        high once the frame has been consumed
//   err_extra   sticky; pixel seen while not running
module rslt_writer #(
  parameter int DATA_WIDTH      = 16,
  parameter int COL_WIDTH       = 8,
  parameter int ROW_WIDTH       = 8,
  parameter int RSLT_ADDR_WIDTH = 12,
  parameter int POOL_BUF_DEPTH  = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pool_en,
  input  logic                       relu_en,
  input  logic [COL_WIDTH-1:0]       result_cols,
  input  logic [ROW_WIDTH-1:0]       result_rows,
  input  logic [RSLT_ADDR_WIDTH-1:0] base_addr,
  input  logic                       pix_valid,
  input  logic [DATA_WIDTH-1:0]      pix_data,
  output logic                       rslt_we,
  output logic [RSLT_ADDR_WIDTH-1:0] rslt_addr,
  output logic [DATA_WIDTH-1:0]      rslt_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       err_extra
);

  localparam int BW =
    (POOL_BUF_DEPTH > 1) ? $clog2(POOL_BUF_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic                       start_d;
  logic                       pool_q;
  logic                       relu_q;
  logic [COL_WIDTH-1:0]       cols_q;
  logic [ROW_WIDTH-1:0]       rows_q;
  logic [COL_WIDTH-1:0]       col_cnt;
  logic [ROW_WIDTH-1:0]       row_cnt;
  logic [RSLT_ADDR_WIDTH-1:0] wr_ptr;
  logic signed [DATA_WIDTH-1:0] h_q;

  logic signed [DATA_WIDTH-1:0] line_buf [POOL_BUF_DEPTH];

  logic                       rise;
  logic                       arm;
  logic                       accept;
  logic                       e_pool;
  logic                       e_relu;
  logic [COL_WIDTH-1:0]       e_cols;
  logic [ROW_WIDTH-1:0]       e_rows;
  logic [COL_WIDTH-1:0]       c;
  logic [ROW_WIDTH-1:0]       r;
  logic [RSLT_ADDR_WIDTH-1:0] ptr;
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] xr;
  logic signed [DATA_WIDTH-1:0] m;
  logic signed [DATA_WIDTH-1:0] lb;
  logic signed [DATA_WIDTH-1:0] pm;
  logic [BW-1:0]              lb_idx;
  logic                       last_col;
  logic                       last_px;
  logic                       pool_hold;
  logic                       pool_store;
  logic                       pool_wr;
  logic                       do_wr;

  // A pixel arriving with the arming edge uses the live config
  // inputs and counters at their start values.
  always_comb begin
    rise   = start & ~start_d;
    arm    = (state == IDLE) & rise;
    accept = pix_valid &
             (arm | ((state == RUN) & start));
    e_pool = arm ? pool_en     : pool_q;
    e_relu = arm ? relu_en     : relu_q;
    e_cols = arm ? result_cols : cols_q;
    e_rows = arm ? result_rows : rows_q;
    c      = arm ? '0          : col_cnt;
    r      = arm ? '0          : row_cnt;
    ptr    = arm ? base_addr   : wr_ptr;
  end

  // Odd trailing column/row need no special case: a last even
  // column only loads h, a last even row only fills line_buf.
  always_comb begin
    x        = $signed(pix_data);
    xr       = (e_relu && x < 0) ? '0 : x;
    m        = (h_q > xr) ? h_q : xr;
    lb_idx   = BW'(c >> 1);
    lb       = line_buf[lb_idx];
    pm       = (lb > m) ? lb : m;
    last_col = (c == e_cols);
    last_px  = last_col && (r == e_rows);
    pool_hold  = accept & e_pool & ~c[0];
    pool_store = accept & e_pool & c[0] & ~r[0];
    pool_wr    = accept & e_pool & c[0] & r[0];
    do_wr      = (accept & ~e_pool) | pool_wr;
  end

  always_ff @(posedge clk) begin
    if (pool_store)
      line_buf[lb_idx] <= m;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      start_d    <= 1'b0;
      pool_q     <= 1'b0;
      relu_q     <= 1'b0;
      cols_q     <= '0;
      rows_q     <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      wr_ptr     <= '0;
      h_q        <= '0;
      rslt_we    <= 1'b0;
      rslt_addr  <= '0;
      rslt_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_extra  <= 1'b0;
    end else begin
      start_d <= start;
      rslt_we <= 1'b0;

      unique case (state)
        IDLE: begin
          if (rise) begin
            pool_q    <= pool_en;
            relu_q    <= relu_en;
            cols_q    <= result_cols;
            rows_q    <= result_rows;
            col_cnt   <= '0;
            row_cnt   <= '0;
            wr_ptr    <= base_addr;
            err_extra <= 1'b0;
            if (accept && last_px) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else if (pix_valid) begin
            err_extra <= 1'b1;
          end
        end
        RUN: begin
          if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept && last_px) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (pix_valid)
            err_extra <= 1'b1;
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase

      // Overrides the counter/pointer loads done on arming.
      if (accept) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= r + 1'b1;
        end else begin
          col_cnt <= c + 1'b1;
          row_cnt <= r;
        end
        if (pool_hold)
          h_q <= xr;
        if (do_wr) begin
          rslt_we    <= 1'b1;
          rslt_addr  <= ptr;
          rslt_wdata <= e_pool ? pm : xr;
          wr_ptr     <= ptr + 1'b1;
        end else begin
          wr_ptr <= ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_rslt_writer.sv
// tb_rslt_writer: directed bench for rslt_writer.
// Linear stimulus, immediate-assertion checks.
module tb_rslt_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        pool_en;
  logic        relu_en;
  logic [7:0]  result_cols;
  logic [7:0]  result_rows;
  logic [11:0] base_addr;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        rslt_we;
  logic [11:0] rslt_addr;
  logic [15:0] rslt_wdata;
  logic        busy;
  logic        done;
  logic        err_extra;

  int checks = 0;
  int errors = 0;
  int wcnt   = 0;
  int nexp   = 0;

  logic [11:0] exp_addr [8];
  logic [15:0] exp_data [8];

  logic [15:0] pv  [4];
  logic [15:0] ev  [4];

  rslt_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pool_en    (pool_en),
    .relu_en    (relu_en),
    .result_cols(result_cols),
    .result_rows(result_rows),
    .base_addr  (base_addr),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .rslt_we    (rslt_we),
    .rslt_addr  (rslt_addr),
    .rslt_wdata (rslt_wdata),
    .busy       (busy),
    .done       (done),
    .err_extra  (err_extra)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick and score any write against the expected list.
  task automatic cyc();
    tick();
    if (rslt_we) begin
      if (wcnt < nexp) begin
        chk("pool_addr", rslt_addr, exp_addr[wcnt]);
        chk("pool_data", rslt_wdata, exp_data[wcnt]);
      end else begin
        chk("extra_write", 1, 0);
      end
      wcnt++;
    end
  endtask

  task automatic run_relu(input logic relu);
    relu_en     = relu;
    pool_en     = 1'b0;
    result_cols = 8'd3;
    result_rows = 8'd0;
    base_addr   = 12'h040;
    start       = 1'b1;
    tick();
    chk("relu_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_data  = pv[i];
      tick();
      chk("relu_we", rslt_we, 1);
      chk("relu_addr", rslt_addr, 12'h040 + 12'(i));
      chk("relu_data", rslt_wdata, ev[i]);
    end
    pix_valid = 1'b0;
    chk("relu_done", done, 1);
    start = 1'b0;
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    pool_en     = 1'b0;
    relu_en     = 1'b0;
    result_cols = '0;
    result_rows = '0;
    base_addr   = '0;
    pix_valid   = 1'b0;
    pix_data    = '0;

    #12;
    chk("rst_we", rslt_we, 0);
    chk("rst_addr", rslt_addr, 0);
    chk("rst_wdata", rslt_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_extra, 0);
    reset = 1'b1;
    tick();

    // No pool, 4x2, pixel on the arming edge.
    result_cols = 8'd3;
    result_rows = 8'd1;
    base_addr   = 12'h010;
    start       = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 16'd1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("np_we", rslt_we, 1);
      chk("np_addr", rslt_addr, 12'h00F + 12'(i));
      chk("np_data", rslt_wdata, 16'(i));
      chk("np_done", done, (i == 8) ? 1 : 0);
      chk("np_busy", busy, (i == 8) ? 0 : 1);
      if (i < 8) pix_data = 16'(i + 1);
      else pix_valid = 1'b0;
    end
    tick();
    chk("np_we_end", rslt_we, 0);
    chk("np_done_hold", done, 1);
    start = 1'b0;
    tick();
    chk("np_done_fall", done, 0);

    // ReLU on, then off.
    pv = '{16'hFFFB, 16'd7, 16'h8000, 16'd0};
    ev = '{16'd0, 16'd7, 16'd0, 16'd0};
    run_relu(1'b1);
    ev = '{16'hFFFB, 16'd7, 16'h8000, 16'd0};
    run_relu(1'b0);
    relu_en = 1'b0;

    // Pool 4x4 with random gaps.
    pool_en     = 1'b1;
    result_cols = 8'd3;
    result_rows = 8'd3;
    base_addr   = 12'h100;
    exp_addr    = '{12'h100, 12'h101, 12'h102, 12'h103,
                    12'h0, 12'h0, 12'h0, 12'h0};
    exp_data    = '{16'd5, 16'd7, 16'd13, 16'd15,
                    16'd0, 16'd0, 16'd0, 16'd0};
    nexp  = 4;
    wcnt  = 0;
    start = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(k);
      cyc();
      pix_valid = 1'b0;
      if (k == 15) begin
        chk("p4_done", done, 1);
        chk("p4_last_we", rslt_we, 1);
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
    cyc();
    chk("p4_count", wcnt, 4);
    start = 1'b0;
    cyc();

    // Pool 5x3 with address wrap.
    result_cols = 8'd4;
    result_rows = 8'd2;
    base_addr   = 12'hFFF;
    exp_addr[0] = 12'hFFF;
    exp_addr[1] = 12'h000;
    exp_data[0] = 16'd6;
    exp_data[1] = 16'd8;
    nexp  = 2;
    wcnt  = 0;
    start = 1'b1;
    cyc();
    for (int k = 0; k < 15; k++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(k);
      cyc();
      if (k == 13) chk("odd_done_early", done, 0);
      if (k == 14) begin
        chk("odd_done", done, 1);
        chk("odd_last_we", rslt_we, 0);
      end
    end
    pix_valid = 1'b0;
    cyc();
    chk("odd_count", wcnt, 2);
    start   = 1'b0;
    pool_en = 1'b0;
    cyc();

    // Abort after 3 pixels, idle pixel, restart.
    result_cols = 8'd3;
    result_rows = 8'd3;
    base_addr   = 12'h020;
    start       = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 16'd11;
    tick();
    chk("ab_addr0", rslt_addr, 12'h020);
    pix_data = 16'd12;
    tick();
    pix_data = 16'd13;
    tick();
    chk("ab_inflight_we", rslt_we, 1);
    chk("ab_inflight_addr", rslt_addr, 12'h022);
    start    = 1'b0;
    pix_data = 16'd14;
    tick();
    chk("ab_no_write", rslt_we, 0);
    chk("ab_busy", busy, 0);
    chk("ab_err_clear", err_extra, 0);
    pix_data = 16'd99;
    tick();
    chk("ab_err_set", err_extra, 1);
    chk("ab_idle_we", rslt_we, 0);
    pix_valid = 1'b0;
    start     = 1'b1;
    tick();
    chk("ab_err_rearm", err_extra, 0);
    chk("ab_busy_rearm", busy, 1);
    pix_valid = 1'b1;
    pix_data  = 16'd50;
    tick();
    chk("ab_re_we", rslt_we, 1);
    chk("ab_re_addr", rslt_addr, 12'h020);
    chk("ab_re_data", rslt_wdata, 16'd50);
    pix_valid = 1'b0;
    start     = 1'b0;
    tick();

    // Async reset mid-run.
    base_addr = 12'h300;
    start     = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 16'd7;
    tick();
    chk("ar_we_pre", rslt_we, 1);
    pix_data = 16'd8;
    #3;
    reset = 1'b0;
    #1;
    chk("ar_we", rslt_we, 0);
    chk("ar_addr", rslt_addr, 0);
    chk("ar_wdata", rslt_wdata, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    start    = 1'b0;
    pix_data = 16'd9;
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick();
    chk("ar_no_write", rslt_we, 0);
    chk("ar_busy_idle", busy, 0);
    start    = 1'b1;
    pix_data = 16'd10;
    tick();
    chk("ar_re_we", rslt_we, 1);
    chk("ar_re_addr", rslt_addr, 12'h300);
    chk("ar_re_data", rslt_wdata, 16'd10);
    pix_valid = 1'b0;
    start     = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
